// File: rtl/ctrl_pkg.sv
// Shared encodings for the SimpleRISC multi-cycle control unit: opcodes,
// FSM state codes, opcode classes, mux-select, PC-source, trap and ALU codes.
package ctrl_pkg;

  // Opcode values as seen in the instruction register opcode field
  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_LW   = 3;
  localparam int unsigned OP_SW   = 4;
  localparam int unsigned OP_BEQ  = 5;
  localparam int unsigned OP_JUMP = 6;
  localparam int unsigned OP_RET  = 7;

  // FSM state codes
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // Instruction classes that drive sequencing after DECODE
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_RET
  } op_class_e;

  // Next-PC source select
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RETADR = 2'b11;

  // Trap cause codes
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  // Two-way datapath mux selects (reg_dst, alu_src, mem_to_reg)
  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: classifies an opcode, picks its ALU
// operation and flags encodings outside the defined instruction set.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [OPCODE_W-1:0]   op,
  output op_class_e             op_class,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  is_illegal
);

  logic [31:0] op_ext;

  assign op_ext = 32'(op);

  // Map opcode to class / ALU op; anything unlisted is illegal
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    op_class    = CLS_NOP;
    alu_control = ALU_CTRL_W'(ALU_ADD);
    is_illegal  = 1'b0;
    case (op_ext)
      OP_NOP:  op_class = CLS_NOP;
      OP_ADD:  op_class = CLS_ALU;
      OP_SUB: begin
        op_class    = CLS_ALU;
        alu_control = ALU_CTRL_W'(ALU_SUB);
      end
      OP_LW:   op_class = CLS_LOAD;
      OP_SW:   op_class = CLS_STORE;
      OP_BEQ: begin
        op_class    = CLS_BRANCH;
        alu_control = ALU_CTRL_W'(ALU_SUB);
      end
      OP_JUMP: op_class = CLS_JUMP;
      OP_RET:  op_class = CLS_RET;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for SimpleRISC: sequences FETCH/DECODE/EXEC/MEM/WB,
// waits on mem_ready with a timeout, honours stall, traps on illegal opcodes
// or memory timeout, and counts retired instructions.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int WAIT_MAX   = 15,
  parameter int RETIRED_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  input  logic                  stall,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            alu_src,
  output logic [1:0]            mem_to_reg,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  instr_done,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [RETIRED_W-1:0]  retired
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  logic [2:0]            state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_sel;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [RETIRED_W-1:0]  retired_q;
  logic [1:0]            trap_cause_q, trap_cause_d;

  op_class_e             cls;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  dec_illegal;
  logic                  wait_expired;
  logic                  pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, done_raw;

  // DECODE looks at the live opcode; later states use the latched copy
  assign op_sel = (state_q == S_DECODE) ? opcode : op_q;

  ctrl_decode #(
    .OPCODE_W   (OPCODE_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_decode (
    .op          (op_sel),
    .op_class    (cls),
    .alu_control (dec_alu),
    .is_illegal  (dec_illegal)
  );

  // Last permitted wait cycle with memory still not ready
  assign wait_expired = (wait_q == WAIT_W'(WAIT_MAX - 1)) && !mem_ready;

  // Next-state, trap-cause and wait-counter selection
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d      = S_TRAP;
          trap_cause_d = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d      = S_TRAP;
          trap_cause_d = TC_ILLEGAL;
        end else begin
          case (cls)
            CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_d = S_EXEC;
            default:                                  state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC: begin
        case (cls)
          CLS_ALU:             state_d = S_WB;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls == CLS_LOAD) ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d      = S_TRAP;
          trap_cause_d = TC_TIMEOUT;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Datapath enables and selects decoded from state, op class and flags
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    done_raw      = 1'b0;
    mem_read      = 1'b0;
    reg_dst       = SEL_0;
    alu_src       = SEL_0;
    mem_to_reg    = SEL_0;
    pc_src        = PC_SEQ;
    alu_control   = ALU_CTRL_W'(ALU_ADD);
    trap          = 1'b0;
    // NOTE: gating with rst_n keeps every output quiet while reset is held,
    // even before the synchronous reset edge has moved the state to IDLE.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            pc_src       = PC_SEQ;
          end
        end
        S_DECODE: begin
          if (!dec_illegal) begin
            case (cls)
              CLS_NOP:  done_raw = 1'b1;
              CLS_JUMP: begin
                pc_write_raw = 1'b1;
                pc_src       = PC_JUMP;
                done_raw     = 1'b1;
              end
              CLS_RET: begin
                pc_write_raw = 1'b1;
                pc_src       = PC_RETADR;
                done_raw     = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          case (cls)
            CLS_ALU: begin
              alu_control = dec_alu;
              alu_src     = SEL_0;
              reg_dst     = SEL_1;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src     = SEL_1;
              alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            CLS_BRANCH: begin
              alu_control  = dec_alu;
              pc_write_raw = alu_zero;
              pc_src       = PC_BRANCH;
              done_raw     = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls == CLS_LOAD) begin
            mem_read = 1'b1;
          end else begin
            mem_write_raw = 1'b1;
            done_raw      = mem_ready;
          end
        end
        S_WB: begin
          reg_write_raw = 1'b1;
          done_raw      = 1'b1;
          if (cls == CLS_LOAD) begin
            mem_to_reg = SEL_1;
            reg_dst    = SEL_0;
          end else begin
            mem_to_reg = SEL_0;
            reg_dst    = SEL_1;
          end
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  // Stall suppresses every write-type strobe; selects and mem_read persist
  assign pc_write   = pc_write_raw  & ~stall;
  assign ir_write   = ir_write_raw  & ~stall;
  assign reg_write  = reg_write_raw & ~stall;
  assign mem_write  = mem_write_raw & ~stall;
  assign instr_done = done_raw      & ~stall;
  assign trap_cause = rst_n ? trap_cause_q : TC_NONE;
  assign retired    = rst_n ? retired_q : '0;

  // State, latched opcode, wait counter, retire counter and trap cause
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      wait_q       <= '0;
      retired_q    <= '0;
      trap_cause_q <= TC_NONE;
    end else if (!stall) begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      trap_cause_q <= trap_cause_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (done_raw) begin
        retired_q <= retired_q + RETIRED_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm. Each cycle drives
// inputs just after the rising edge and compares the packed control outputs
// against a hand-computed vector before the next edge.
module tb_multicycle_control_fsm;

  localparam logic [4:0] NOP  = 5'd0;
  localparam logic [4:0] ADD  = 5'd1;
  localparam logic [4:0] SUB  = 5'd2;
  localparam logic [4:0] LW   = 5'd3;
  localparam logic [4:0] SW   = 5'd4;
  localparam logic [4:0] BEQ  = 5'd5;
  localparam logic [4:0] JUMP = 5'd6;
  localparam logic [4:0] RET  = 5'd7;
  localparam logic [4:0] ILL  = 5'h1F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        mem_ready, alu_zero, stall;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write;
  logic [1:0]  reg_dst, alu_src, mem_to_reg, pc_src;
  logic [3:0]  alu_control;
  logic        instr_done, trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  logic [20:0] ctl;
  int tests_run    = 0;
  int tests_failed = 0;

  logic [20:0] e_idle, e_f_rdy, e_f_wait, e_dec, e_d_nop, e_d_jmp, e_d_ret;
  logic [20:0] e_x_add, e_x_sub, e_x_mem, e_x_beq1, e_x_beq0;
  logic [20:0] e_m_sw_wait, e_m_sw_rdy, e_wb_alu, e_wb_lw, e_wb_stall;
  logic [20:0] e_trap_ill, e_trap_to;

  multicycle_control_fsm #(
    .OPCODE_W   (5),
    .ALU_CTRL_W (4),
    .WAIT_MAX   (15),
    .RETIRED_W  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .stall       (stall),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_dst     (reg_dst),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .pc_src      (pc_src),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, ir_write, reg_write, mem_read, mem_write,
                reg_dst, alu_src, mem_to_reg, pc_src, alu_control,
                instr_done, trap, trap_cause};

  function automatic logic [20:0] pk(input logic pw, irw, rw, mr, mw,
                                     input logic [1:0] rd, as, mtr, ps,
                                     input logic [3:0] alu,
                                     input logic dn, tp,
                                     input logic [1:0] tc);
    return {pw, irw, rw, mr, mw, rd, as, mtr, ps, alu, dn, tp, tc};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance past the edge
  task automatic cyc(input string tag, input logic [4:0] op, input logic rdy,
                     input logic z, input logic stl, input logic [20:0] exp);
    opcode    = op;
    mem_ready = rdy;
    alu_zero  = z;
    stall     = stl;
    #1;
    check(tag, 64'(ctl), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                pw irw rw mr mw rd     as     mtr    ps     alu    dn tp tc
    e_idle      = '0;
    e_f_rdy     = pk(1, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_f_wait    = pk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_dec       = '0;
    e_d_nop     = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 1, 0, 2'b00);
    e_d_jmp     = pk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 4'h0, 1, 0, 2'b00);
    e_d_ret     = pk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 4'h0, 1, 0, 2'b00);
    e_x_add     = pk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_x_sub     = pk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h1, 0, 0, 2'b00);
    e_x_mem     = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_x_beq1    = pk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'h1, 1, 0, 2'b00);
    e_x_beq0    = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'h1, 1, 0, 2'b00);
    e_m_sw_wait = pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_m_sw_rdy  = pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 1, 0, 2'b00);
    e_wb_alu    = pk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 1, 0, 2'b00);
    e_wb_lw     = pk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0, 1, 0, 2'b00);
    e_wb_stall  = pk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0, 2'b00);
    e_trap_ill  = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1, 2'b01);
    e_trap_to   = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1, 2'b10);

    rst_n = 1'b0; opcode = ADD; mem_ready = 1'b1; alu_zero = 1'b0; stall = 1'b0;
    @(posedge clk); #1;

    // Reset: outputs quiet even with active-looking inputs
    cyc("reset_outputs", ADD, 1, 0, 0, e_idle);
    check("reset_retired", 64'(retired), 64'd0);
    rst_n = 1'b1;

    // ADD, memory ready immediately; opcode changed after DECODE
    cyc("add_idle",   ADD, 1, 0, 0, e_idle);
    cyc("add_fetch",  ADD, 1, 0, 0, e_f_rdy);
    cyc("add_decode", ADD, 1, 0, 0, e_dec);
    cyc("add_exec",   ILL, 1, 0, 0, e_x_add);
    check("add_retired_before_wb", 64'(retired), 64'd0);
    cyc("add_wb",     ILL, 1, 0, 0, e_wb_alu);
    check("add_retired", 64'(retired), 64'd1);

    // LW with three MEM wait cycles
    cyc("lw_fetch",  LW, 1, 0, 0, e_f_rdy);
    cyc("lw_decode", LW, 1, 0, 0, e_dec);
    cyc("lw_exec",   NOP, 1, 0, 0, e_x_mem);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", NOP, 0, 0, 0, e_f_wait);
    cyc("lw_mem_rdy", NOP, 1, 0, 0, e_f_wait);
    cyc("lw_wb",      NOP, 1, 0, 0, e_wb_lw);
    check("lw_retired", 64'(retired), 64'd2);

    // BEQ taken then not taken
    cyc("beq1_fetch",  BEQ, 1, 0, 0, e_f_rdy);
    cyc("beq1_decode", BEQ, 1, 0, 0, e_dec);
    cyc("beq1_exec",   BEQ, 1, 1, 0, e_x_beq1);
    cyc("beq0_fetch",  BEQ, 1, 1, 0, e_f_rdy);
    cyc("beq0_decode", BEQ, 1, 1, 0, e_dec);
    cyc("beq0_exec",   BEQ, 1, 0, 0, e_x_beq0);
    check("beq_retired", 64'(retired), 64'd4);

    // Two-cycle instructions
    cyc("nop_fetch",  NOP, 1, 0, 0, e_f_rdy);
    cyc("nop_decode", NOP, 1, 0, 0, e_d_nop);
    cyc("jmp_fetch",  JUMP, 1, 0, 0, e_f_rdy);
    cyc("jmp_decode", JUMP, 1, 0, 0, e_d_jmp);
    cyc("ret_fetch",  RET, 1, 0, 0, e_f_rdy);
    cyc("ret_decode", RET, 1, 0, 0, e_d_ret);
    check("short_retired", 64'(retired), 64'd7);

    // Stall in FETCH ignores mem_ready; stall in WB of SUB holds the write
    for (int i = 0; i < 2; i++) cyc("stall_fetch", SUB, 1, 0, 1, e_f_wait);
    cyc("sub_fetch",  SUB, 1, 0, 0, e_f_rdy);
    cyc("sub_decode", SUB, 1, 0, 0, e_dec);
    cyc("sub_exec",   NOP, 1, 0, 0, e_x_sub);
    for (int i = 0; i < 3; i++) cyc("sub_wb_stall", NOP, 1, 0, 1, e_wb_stall);
    check("sub_retired_held", 64'(retired), 64'd7);
    cyc("sub_wb", NOP, 1, 0, 0, e_wb_alu);
    check("sub_retired", 64'(retired), 64'd8);

    // mem_ready on the 15th counted wait cycle wins, in FETCH and in MEM;
    // stalled cycles do not count toward the timeout
    for (int i = 0; i < 10; i++) cyc("win_fetch_wait", SW, 0, 0, 0, e_f_wait);
    for (int i = 0; i < 3; i++)  cyc("win_fetch_stall", SW, 0, 0, 1, e_f_wait);
    for (int i = 0; i < 4; i++)  cyc("win_fetch_wait2", SW, 0, 0, 0, e_f_wait);
    cyc("win_fetch_rdy", SW, 1, 0, 0, e_f_rdy);
    cyc("win_decode",    SW, 1, 0, 0, e_dec);
    cyc("win_exec",      SW, 1, 0, 0, e_x_mem);
    for (int i = 0; i < 14; i++) cyc("win_mem_wait", SW, 0, 0, 0, e_m_sw_wait);
    cyc("win_mem_rdy", SW, 1, 0, 0, e_m_sw_rdy);
    check("win_retired", 64'(retired), 64'd9);

    // Reset during SW MEM wait
    cyc("rsw_fetch",  SW, 1, 0, 0, e_f_rdy);
    cyc("rsw_decode", SW, 1, 0, 0, e_dec);
    cyc("rsw_exec",   SW, 1, 0, 0, e_x_mem);
    cyc("rsw_mem",    SW, 0, 0, 0, e_m_sw_wait);
    rst_n = 1'b0;
    cyc("rsw_reset",  SW, 1, 0, 0, e_idle);
    rst_n = 1'b1;
    cyc("rsw_idle",   SW, 1, 0, 0, e_idle);
    check("rsw_retired", 64'(retired), 64'd0);

    // FETCH timeout after 15 cycles without mem_ready
    for (int i = 0; i < 15; i++) cyc("to_fetch_wait", NOP, 0, 0, 0, e_f_wait);
    for (int i = 0; i < 3; i++)  cyc("to_trap", NOP, 1, 0, 0, e_trap_to);
    check("to_retired", 64'(retired), 64'd0);

    // Illegal opcode after one retired NOP
    rst_n = 1'b0;
    cyc("ill_reset", NOP, 1, 0, 0, e_idle);
    rst_n = 1'b1;
    cyc("ill_idle",       NOP, 1, 0, 0, e_idle);
    cyc("ill_nop_fetch",  NOP, 1, 0, 0, e_f_rdy);
    cyc("ill_nop_decode", NOP, 1, 0, 0, e_d_nop);
    cyc("ill_fetch",      ILL, 1, 0, 0, e_f_rdy);
    cyc("ill_decode",     ILL, 1, 0, 0, e_dec);
    for (int i = 0; i < 20; i++) cyc("ill_trap", ADD, 1, 1, 1'(i % 2), e_trap_ill);
    check("ill_retired", 64'(retired), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
